// File: rtl/rv32_pkg.sv
// Shared core types.
// Arbiter requester IDs used by mem_arbiter and its ID FIFO.
package rv32_pkg;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_id_e;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of arbiter winner IDs.
// Holds the requester of every granted but unanswered memory access.
module arb_id_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  arb_id_e       id_i,
    input  logic          pop_i,
    output arb_id_e       head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    arb_id_e       mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= next_ptr(wr_q);
            end
            if (do_pop) begin
                rd_q <= next_ptr(rd_q);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one instr/data arbiter onto one req/gnt/rvalid memory port.
// Optional round-robin tie-break: define RV32_ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import rv32_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int AW = 32,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          instr_req_i,
    input  logic [AW-1:0] instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    input  logic          data_req_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    output logic [31:0]   data_rdata_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [31:0]   mem_rdata_i,
    output logic [OW-1:0] outstanding_o,
    output logic          err_o
);

    arb_id_e win;
    arb_id_e tie_win;
    arb_id_e lock_id_q;
    arb_id_e head;
    logic    lock_q;
    logic    err_q;
    logic    locked_req;
    logic    locked_ok;
    logic    hs;
    logic    pop;
    logic    full;
    logic    empty;

    assign locked_req = (lock_id_q == ARB_DATA) ? data_req_i : instr_req_i;
    assign locked_ok  = lock_q & locked_req;

`ifdef RV32_ARB_ROUND_ROBIN_EN
    arb_id_e last_q;

    assign tie_win = (last_q == ARB_DATA) ? ARB_INSTR : ARB_DATA;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= ARB_INSTR;
        end else if (hs) begin
            last_q <= win;
        end
    end
`else
    assign tie_win = ARB_DATA;
`endif

    // A pending ungranted request keeps its slot until the handshake.
    always_comb begin
        win = ARB_INSTR;
        if (locked_ok) begin
            win = lock_id_q;
        end else if (instr_req_i && data_req_i) begin
            win = tie_win;
        end else if (data_req_i) begin
            win = ARB_DATA;
        end
    end

    assign mem_req_o = (instr_req_i | data_req_i) & ~full;
    assign hs        = mem_req_o & mem_gnt_i;

    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = '0;
        if (win == ARB_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign instr_gnt_o = hs & (win == ARB_INSTR);
    assign data_gnt_o  = hs & (win == ARB_DATA);

    assign pop            = mem_rvalid_i & ~empty;
    assign instr_rvalid_o = pop & (head == ARB_INSTR);
    assign data_rvalid_o  = pop & (head == ARB_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign err_o          = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_id_q <= ARB_INSTR;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= mem_req_o & ~mem_gnt_i;
            lock_id_q <= win;
            // Dropped locked request or orphan response.
            err_q     <= err_q | (lock_q & ~locked_req)
                               | (mem_rvalid_i & empty);
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .id_i    (win),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter.
// Reference model tracks tie-break under RV32_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    localparam int MAXO = 2;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          instr_req_i = 1'b0;
    logic [AW-1:0] instr_addr_i = '0;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [31:0]   instr_rdata_o;
    logic          data_req_i = 1'b0;
    logic [AW-1:0] data_addr_i = '0;
    logic          data_we_i = 1'b0;
    logic [3:0]    data_be_i = '0;
    logic [31:0]   data_wdata_i = '0;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [31:0]   data_rdata_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [31:0]   mem_rdata_i = '0;
    logic [1:0]    outstanding_o;
    logic          err_o;

    mem_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .AW              (AW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .outstanding_o  (outstanding_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mq[$];
    int          total = 0;
    int          bad = 0;
    int          pops_exp = 0;
    int          pops_seen = 0;
    logic        lock_m = 1'b0;
    logic        lock_id = 1'b0;
    logic        last_m = 1'b0;
    logic        err_m = 1'b0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hDEADBEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (instr_rvalid_o || data_rvalid_o) begin
                pops_seen++;
                check("rvalid_onehot", 32'(instr_rvalid_o & data_rvalid_o), 0);
                if (sb.size() == 0) begin
                    check("rvalid_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rvalid_id", 32'(data_rvalid_o), 32'(e.id));
                    check("rdata",
                          data_rvalid_o ? data_rdata_o : instr_rdata_o,
                          e.data);
                end
            end
        end
    end

    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [31:0] da,
                        input logic dwe, input logic [3:0] dbe,
                        input logic [31:0] dwd, input logic g,
                        input logic rv, output logic gi, output logic gd);
        logic        ereq;
        logic        lk_ok;
        logic        tie;
        logic        w;
        logic [31:0] ea;
        int          cnt;
        @(posedge clk);
        #1;
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_addr_i  = da;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_wdata_i = dwd;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = (mq.size() > 0) ? mq[0] : $urandom;
        @(negedge clk);
        cnt = mq.size();
        ereq = (ir || dr) && (cnt < MAXO);
        lk_ok = lock_m && (lock_id ? dr : ir);
`ifdef RV32_ARB_ROUND_ROBIN_EN
        tie = ~last_m;
`else
        tie = 1'b1;
`endif
        w = lk_ok ? lock_id : ((ir && dr) ? tie : dr);
        ea = w ? da : ia;
        gi = ereq && g && !w;
        gd = ereq && g && w;
        check("mem_req", 32'(mem_req_o), 32'(ereq));
        if (ereq) begin
            check("mem_addr", mem_addr_o, ea);
            check("mem_we", 32'(mem_we_o), 32'(w ? dwe : 1'b0));
            check("mem_be", 32'(mem_be_o), 32'(w ? dbe : 4'hF));
            check("mem_wdata", mem_wdata_o, w ? dwd : 32'h0);
        end
        check("instr_gnt", 32'(instr_gnt_o), 32'(gi));
        check("data_gnt", 32'(data_gnt_o), 32'(gd));
        check("outstanding", 32'(outstanding_o), 32'(cnt));
        check("err", 32'(err_o), 32'(err_m));
        if (rv && cnt == 0) begin
            check("orphan_rvalid", 32'(instr_rvalid_o | data_rvalid_o), 0);
        end
        if (lock_m && !lk_ok) err_m = 1'b1;
        if (rv) begin
            if (cnt > 0) begin
                void'(mq.pop_front());
                pops_exp++;
            end else begin
                err_m = 1'b1;
            end
        end
        if (ereq && g) begin
            sb.push_back('{w, mdata(ea)});
            mq.push_back(mdata(mem_addr_o));
            last_m = w;
        end
        lock_m = ereq && !g;
        lock_id = w;
    endtask

    task automatic idle(input logic g, input logic rv);
        logic gi;
        logic gd;
        step(0, 0, 0, 0, 0, 0, 0, g, rv, gi, gd);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        instr_req_i = 0;
        data_req_i = 0;
        mem_gnt_i = 0;
        mem_rvalid_i = 0;
        #1;
        check("rst_err", 32'(err_o), 0);
        check("rst_outstanding", 32'(outstanding_o), 0);
        check("rst_gnt", 32'(instr_gnt_o | data_gnt_o | mem_req_o), 0);
        sb.delete();
        mq.delete();
        lock_m = 0;
        last_m = 0;
        err_m = 0;
        @(posedge clk);
        #3;
        rst_ni = 1'b1;
    endtask

    initial begin : main
        logic gi;
        logic gd;
        logic ir;
        logic dr;
        logic dwe;
        logic [3:0] dbe;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        repeat (3) @(posedge clk);
        #1;
        check("init_err", 32'(err_o), 0);
        check("init_outstanding", 32'(outstanding_o), 0);
        check("init_gnt", 32'(instr_gnt_o | data_gnt_o | mem_req_o), 0);
        rst_ni = 1'b1;

        // single instruction read
        step(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, gi, gd);
        idle(1, 1);
        idle(1, 0);

        // both requesting, data first then instruction
        step(1, 32'h0, 1, 32'h200, 1, 4'h3, 32'h1234, 1, 0, gi, gd);
        step(1, 32'h0, 0, 0, 0, 0, 0, 1, 1, gi, gd);
        idle(1, 1);
        idle(1, 0);

        // lock holds instruction against a later data request
        repeat (3) step(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, gi, gd);
        step(1, 32'h300, 1, 32'h400, 0, 4'hF, 0, 0, 0, gi, gd);
        step(1, 32'h300, 1, 32'h400, 0, 4'hF, 0, 1, 0, gi, gd);
        step(0, 0, 1, 32'h400, 0, 4'hF, 0, 1, 1, gi, gd);
        idle(1, 1);
        idle(1, 0);

        // FIFO full blocks grants, even with a same-cycle pop
        repeat (3) step(1, 32'h500, 1, 32'h600, 0, 4'h1, 7, 1, 0, gi, gd);
        step(1, 32'h500, 1, 32'h600, 0, 4'h1, 7, 1, 1, gi, gd);
        step(1, 32'h500, 1, 32'h600, 0, 4'h1, 7, 1, 0, gi, gd);
        repeat (4) idle(1, mq.size() > 0);

        // continuous contention with gnt always high
        repeat (6) step(1, 32'h700, 1, 32'h800, 1, 4'hC, 9, 1,
                        mq.size() > 0, gi, gd);
        repeat (4) idle(1, mq.size() > 0);

        // orphan response sets sticky err, async reset clears it
        idle(1, 1);
        idle(1, 0);
        idle(1, 0);
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_err_clear", 32'(err_o), 0);
        rst_ni = 1'b1;
        err_m = 0;
        lock_m = 0;
        last_m = 0;

        // locked requester drops its request
        step(1, 32'h900, 0, 0, 0, 0, 0, 0, 0, gi, gd);
        step(0, 0, 1, 32'hA00, 1, 4'hF, 5, 1, 0, gi, gd);
        idle(1, 0);
        do_reset();

        // randomized traffic
        ir = 0;
        dr = 0;
        ia = 0;
        da = 0;
        dwe = 0;
        dbe = 0;
        dwd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!ir && ($urandom % 2 == 0)) begin
                ir = 1;
                ia = $urandom;
            end
            if (!dr && ($urandom % 2 == 0)) begin
                dr = 1;
                da = $urandom;
                dwe = 1'($urandom);
                dbe = 4'($urandom);
                dwd = $urandom;
            end
            step(ir, ia, dr, da, dwe, dbe, dwd, ($urandom % 4) != 0,
                 (mq.size() > 0) && ($urandom % 2 == 0), gi, gd);
            if (gi) ir = 0;
            if (gd) dr = 0;
        end

        for (int i = 0; i < 20 && mq.size() > 0; i++) begin
            idle(0, 1);
        end
        idle(0, 0);
        check("drain_mem", 32'(mq.size()), 0);
        check("drain_sb", 32'(sb.size()), 0);
        check("pop_count", 32'(pops_seen), 32'(pops_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-to-one arbiter that shares one single-port req/gnt/rvalid memory between the core's instruction and data ports, allowing a unified memory_model instance.
Grants one request per cycle and records the winner's ID in an in-order FIFO. Routes each mem_rvalid_i back to the requester that issued it.
Sits between rv32_core and the memory in the unified-memory top.

Parameters:
MAX_OUTSTANDING, 2, depth of the ID FIFO (maximum accepted but unanswered transactions); power of two, at least 1.
AW, 32, address width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_req_i  in  1  instruction request
instr_addr_i  in  AW  instruction address
instr_gnt_o  out  1  instruction grant
instr_rvalid_o  out  1  instruction read data valid
instr_rdata_o  out  32  instruction read data
data_req_i  in  1  data request
data_addr_i  in  AW  data address
data_we_i  in  1  data write enable
data_be_i  in  4  data byte enables
data_wdata_i  in  32  data write data
data_gnt_o  out  1  data grant
data_rvalid_o  out  1  data response valid
data_rdata_o  out  32  data read data
mem_req_o  out  1  memory request
mem_addr_o  out  AW  memory address
mem_we_o  out  1  memory write enable
mem_be_o  out  4  memory byte enables
mem_wdata_o  out  32  memory write data
mem_gnt_i  in  1  memory grant
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  32  memory read data
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  number of IDs in the FIFO
err_o  out  1  sticky protocol-error flag

Behaviour:
- Clock clk_i, single domain. Reset rst_ni is asynchronous, active-low.
- Reset state:
  - FIFO empty, outstanding_o=0, err_o=0.
  - Lock cleared. Round-robin pointer set to "last=instr".
  - All gnt and rvalid outputs 0 whenever no request or response is present.
- Grant logic (combinational from state and inputs):
  - mem_req_o = (instr_req_i | data_req_i) & ~fifo_full.
  - A full FIFO blocks all grants, even if a pop occurs in the same cycle.
- Winner selection: fixed priority, data over instr.
- Mux: winner drives mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o. An instr winner drives we=0, be=4'hF, wdata=0.
- Grant routing:
  - The winner's gnt_o = mem_gnt_i & mem_req_o.
  - The loser's gnt_o is 0.
- Lock:
  - If mem_req_o=1 and mem_gnt_i=0, register the winner; the next cycle must select the same requester.
  - The lock holds until the handshake, or until the locked requester drops req (a protocol violation: set err_o and release the lock).
  - The lock overrides priority, so a request to the memory stays stable until granted.
- Push: on a handshake (mem_req_o & mem_gnt_i), push the winner ID at the clock edge. A response is never accepted in the grant cycle, so the earliest response is the next cycle.
- Pop and routing:
  - On mem_rvalid_i with the FIFO non-empty, pop the head and assert rvalid_o of the head ID in the same cycle (combinational).
  - mem_rdata_i goes to both rdata outputs unconditionally.
- Simultaneous push and pop: allowed when not full; count is unchanged.
- mem_rvalid_i with the FIFO empty: no rvalid_o, no pop, err_o set. err_o is cleared only by reset.
- Reset mid-transaction: FIFO flushed. Late responses after reset hit the empty-FIFO path and set err_o.
- Writes produce an rvalid like reads (matches memory_model behaviour).

Optional Feature:
RV32_ARB_ROUND_ROBIN_EN
- Defined:
  - On a simultaneous request with no lock active, the requester not granted most recently wins.
  - The pointer updates only on a handshake.
  - With the reset pointer, data wins the first tie.
- Undefined: fixed data-over-instr priority, and no pointer register exists.

Decomposition:
- rv32_pkg gains `typedef enum logic {ARB_INSTR=1'b0, ARB_DATA=1'b1} arb_id_e`.
- One sub-module: arb_id_fifo, a synchronous FIFO of arb_id_e, depth MAX_OUTSTANDING, with push, pop, full, empty and count, and asynchronous reset to empty.
- Lock, pointer and error flag live in mem_arbiter.

Test Plan:
1. Instr read alone at 0x100, mem gnt immediate, rvalid next cycle with 0xDEADBEEF -> instr_gnt_o=1 in cycle 0; instr_rvalid_o=1 with rdata 0xDEADBEEF in cycle 1; data_rvalid_o=0; outstanding_o goes 0→1→0.
2. Both requesting (instr 0x0, data write 0x200 be=4'h3 wdata 0x1234), fixed priority:
   - Cycle 0: data granted, mem_we_o=1, mem_be_o=4'h3.
   - Cycle 1: instr granted.
   - Responses route in order: data_rvalid_o, then instr_rvalid_o.
3. mem_gnt_i held 0 for 3 cycles while instr is requesting, then data asserts req -> mem_addr_o stays at the instr address (lock); instr is granted first when gnt rises.
4. MAX_OUTSTANDING=2, gnt always 1, rvalid withheld:
   - After 2 handshakes: mem_req_o=0, outstanding_o=2.
   - First rvalid: pop occurs, grant resumes the following cycle.
5. mem_rvalid_i pulse with the FIFO empty -> no rvalid_o, err_o=1 and stays 1; rst_ni low clears it asynchronously.
6. With RV32_ARB_ROUND_ROBIN_EN, both requesting continuously with gnt always 1 -> grants alternate D, I, D, I; without the macro, grants are D, D, D, D.
